// File: rtl/key_interrupt_arbiter.sv
// Interrupt-source controller: synchronised key/frame edges latched as pending
// bits, arbitrated (fixed or round-robin) onto a valid/ack CPU interrupt port.
module key_interrupt_arbiter #(
    parameter int         NUM_KEYS   = 4,
    parameter bit         RR_MODE    = 1'b0,
    parameter logic [4:0] INT_OPCODE = 5'b11111,
    parameter int         DROP_W     = 8
) (
    input  logic                proc_clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                frame_rt_clk,
    input  logic                int_ack,
    output logic [31:0]         interrupt_instruction,
    output logic                int_valid,
    output logic [NUM_KEYS:0]   pending,
    output logic [DROP_W-1:0]   drop_count
);

    localparam int NUM_SRC = NUM_KEYS + 1;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] raw;
    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;
    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] evt;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] drop_hit;
    logic [31:0]        pend_pad;
    logic [4:0]         rr_ptr;
    logic [4:0]         start;
    logic [4:0]         sel;
    logic [4:0]         ptr_nxt;
    logic               found;
    logic               grant;
    int                 idx;

    // Frame tick sits above the keys so it loses fixed-priority ties.
    assign raw      = {frame_rt_clk, keys};
    assign evt      = sync2 & ~prev;
    assign start    = RR_MODE ? rr_ptr : 5'd0;
    assign pend_pad = 32'(pending);

    always_comb begin
        found = 1'b0;
        sel   = 5'd0;
        idx   = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = int'(start) + i;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!found && pend_pad[idx[4:0]]) begin
                found = 1'b1;
                sel   = idx[4:0];
            end
        end
    end

    assign grant    = (state == IDLE) && found;
    assign clr      = grant ? (NUM_SRC'(1) << sel) : '0;
    assign drop_hit = evt & pending & ~clr;
    assign ptr_nxt  = (sel == 5'(NUM_SRC - 1)) ? 5'd0 : sel + 5'd1;

    always_ff @(posedge proc_clk) begin
        if (reset) begin
            state                 <= IDLE;
            sync1                 <= '0;
            sync2                 <= '0;
            prev                  <= '0;
            pending               <= '0;
            drop_count            <= '0;
            rr_ptr                <= 5'd0;
            int_valid             <= 1'b0;
            interrupt_instruction <= 32'd0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            prev    <= sync2;
            // A fresh edge re-arms a source even on the cycle it is issued.
            pending <= (pending & ~clr) | evt;
            if (|drop_hit && drop_count != '1)
                drop_count <= drop_count + DROP_W'(1);
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        int_valid             <= 1'b1;
                        interrupt_instruction <= {INT_OPCODE, 22'd0, sel};
                        rr_ptr                <= ptr_nxt;
                        state                 <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (int_ack) begin
                        int_valid             <= 1'b0;
                        interrupt_instruction <= 32'd0;
                        state                 <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_interrupt_arbiter.sv
// Bench for key_interrupt_arbiter: fixed-priority and round-robin instances
// checked every cycle against an edge/queue model plus literal expectations.
module tb_key_interrupt_arbiter;

    localparam int NK = 4;
    localparam int NS = NK + 1;

    logic          proc_clk = 1'b0;
    logic          reset;
    logic [NK-1:0] keys;
    logic          frame_rt_clk;
    logic          int_ack;

    logic [31:0]   fx_instr, rr_instr;
    logic          fx_valid, rr_valid;
    logic [NS-1:0] fx_pend, rr_pend;
    logic [7:0]    fx_drop;
    logic [1:0]    rr_drop;

    int total = 0;
    int bad   = 0;

    always #5 proc_clk = ~proc_clk;

    key_interrupt_arbiter #(
        .NUM_KEYS(NK), .RR_MODE(1'b0), .INT_OPCODE(5'b11111), .DROP_W(8)
    ) dut_fx (
        .proc_clk(proc_clk), .reset(reset), .keys(keys),
        .frame_rt_clk(frame_rt_clk), .int_ack(int_ack),
        .interrupt_instruction(fx_instr), .int_valid(fx_valid),
        .pending(fx_pend), .drop_count(fx_drop)
    );

    key_interrupt_arbiter #(
        .NUM_KEYS(NK), .RR_MODE(1'b1), .INT_OPCODE(5'b11111), .DROP_W(2)
    ) dut_rr (
        .proc_clk(proc_clk), .reset(reset), .keys(keys),
        .frame_rt_clk(frame_rt_clk), .int_ack(int_ack),
        .interrupt_instruction(rr_instr), .int_valid(rr_valid),
        .pending(rr_pend), .drop_count(rr_drop)
    );

    // h0/h1/h2: raw samples taken 1, 2 and 3 edges ago.
    typedef struct {
        bit [NS-1:0] h0, h1, h2;
        bit          valid;
        int          src;
        bit [NS-1:0] pend;
        int          drop;
        int          ptr;
    } model_t;

    model_t mf, mr;

    task automatic step(inout model_t m, input bit rr, input int dmax,
                        input bit [NS-1:0] raw, input bit rst, input bit ack);
        bit [NS-1:0] ev, clr;
        bit g, fnd;
        int src, st, j;
        if (rst) begin
            m.h0 = '0; m.h1 = '0; m.h2 = '0;
            m.valid = 0; m.src = 0; m.pend = '0; m.drop = 0; m.ptr = 0;
        end else begin
            ev  = m.h1 & ~m.h2;
            g   = !m.valid && (m.pend != '0);
            clr = '0;
            src = 0;
            fnd = 0;
            if (g) begin
                st = rr ? m.ptr : 0;
                for (int k = 0; k < NS; k++) begin
                    j = (st + k) % NS;
                    if (!fnd && m.pend[j]) begin
                        fnd = 1;
                        src = j;
                    end
                end
                clr[src] = 1'b1;
            end
            if ((ev & m.pend & ~clr) != '0 && m.drop < dmax) m.drop++;
            m.pend = (m.pend & ~clr) | ev;
            if (m.valid) begin
                if (ack) m.valid = 0;
            end else if (g) begin
                m.valid = 1;
                m.src   = src;
                m.ptr   = (src + 1) % NS;
            end
            m.h2 = m.h1; m.h1 = m.h0; m.h0 = raw;
        end
    endtask

    function automatic logic [31:0] exp_instr(model_t m);
        return m.valid ? {5'b11111, 22'd0, 5'(m.src)} : 32'd0;
    endfunction

    initial begin
        mf = '{default: 0};
        mr = '{default: 0};
        forever begin
            @(posedge proc_clk);
            step(mf, 1'b0, 255, {frame_rt_clk, keys}, reset, int_ack);
            step(mr, 1'b1, 3, {frame_rt_clk, keys}, reset, int_ack);
        end
    end

    task automatic cmp(string nm, logic [31:0] ai, logic av,
                       logic [NS-1:0] ap, logic [7:0] ad, model_t m);
        total++;
        if (ai !== exp_instr(m) || av !== m.valid || ap !== m.pend ||
            ad !== 8'(m.drop)) begin
            bad++;
            $display("FAIL %s model t=%0t: instr=%h valid=%b pend=%b drop=%0d, want instr=%h valid=%b pend=%b drop=%0d",
                     nm, $time, ai, av, ap, ad, exp_instr(m), m.valid, m.pend, m.drop);
        end
    endtask

    initial begin
        forever begin
            @(negedge proc_clk);
            cmp("fx", fx_instr, fx_valid, fx_pend, fx_drop, mf);
            cmp("rr", rr_instr, rr_valid, rr_pend, 8'(rr_drop), mr);
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge proc_clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic grant_fx(string nm, logic [31:0] want);
        bit ok;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (fx_valid === 1'b1) ok = 1;
            else cyc(1);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s: no int_valid within 30 cycles", nm);
        end else begin
            chk(nm, fx_instr, want);
        end
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
    endtask

    task automatic pulse(logic [NK-1:0] k);
        keys = k;
        cyc(2);
        keys = '0;
        cyc(2);
    endtask

    int order[$];
    bit rr_done;

    initial begin
        reset        = 1'b1;
        keys         = 4'b1010;
        frame_rt_clk = 1'b0;
        int_ack      = 1'b0;

        // reset with keys held, then 3-cycle latency
        cyc(2);
        chk("rst_instr", fx_instr, 32'd0);
        chk("rst_valid", 32'(fx_valid), 32'd0);
        chk("rst_pend", 32'(fx_pend), 32'd0);
        chk("rst_drop", 32'(fx_drop), 32'd0);
        reset = 1'b0;
        cyc(2);
        chk("e1_pend", 32'(fx_pend), 32'd0);
        cyc(1);
        chk("e2_pend", 32'(fx_pend), 32'b01010);
        cyc(1);
        chk("e3_valid", 32'(fx_valid), 32'd1);
        chk("e3_instr", fx_instr, 32'hF800_0001);
        chk("e3_pend", 32'(fx_pend), 32'b01000);
        keys    = '0;
        int_ack = 1'b1;
        cyc(1);
        chk("ack_low", 32'(fx_valid), 32'd0);
        int_ack = 1'b0;
        cyc(1);
        chk("second", fx_instr, 32'hF800_0003);
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;

        // single key, held output under no ack
        do_reset();
        keys = 4'b0100;
        cyc(3);
        keys = '0;
        chk("k2_pend", 32'(fx_pend), 32'b00100);
        cyc(1);
        chk("k2_valid", 32'(fx_valid), 32'd1);
        chk("k2_instr", fx_instr, 32'hF800_0002);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("k2_hold", fx_instr, 32'hF800_0002);
        end
        int_ack = 1'b1;
        cyc(1);
        int_ack = 1'b0;
        chk("k2_ackv", 32'(fx_valid), 32'd0);
        chk("k2_acki", fx_instr, 32'd0);
        chk("k2_ackp", 32'(fx_pend), 32'd0);

        // simultaneous keys 0, 3 and frame
        do_reset();
        keys         = 4'b1001;
        frame_rt_clk = 1'b1;
        cyc(3);
        keys         = '0;
        frame_rt_clk = 1'b0;
        grant_fx("fix0", 32'hF800_0000);
        grant_fx("fix3", 32'hF800_0003);
        grant_fx("fix4", 32'hF800_0004);

        // round-robin with every source re-pended every 4 cycles
        do_reset();
        rr_done = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    keys = '1; frame_rt_clk = 1'b1;
                    cyc(2);
                    keys = '0; frame_rt_clk = 1'b0;
                    cyc(2);
                end
            end
            begin
                for (int g = 0; g < 6; g++) begin
                    bit ok;
                    ok = 0;
                    for (int i = 0; i < 30 && !ok; i++) begin
                        if (rr_valid === 1'b1) ok = 1;
                        else cyc(1);
                    end
                    if (ok) order.push_back(int'(rr_instr[4:0]));
                    else order.push_back(-1);
                    int_ack = 1'b1;
                    cyc(1);
                    int_ack = 1'b0;
                end
            end
        join
        for (int g = 0; g < 6; g++)
            chk("rr_order", 32'(order[g]), 32'(g % NS));

        // drops while key1 is stuck pending behind an unacked key0
        do_reset();
        pulse(4'b0011);
        for (int i = 0; i < 3; i++) pulse(4'b0010);
        chk("drop3_fx", 32'(fx_drop), 32'd3);
        chk("drop3_rr", 32'(rr_drop), 32'd3);
        for (int i = 0; i < 2; i++) pulse(4'b0010);
        chk("drop5_fx", 32'(fx_drop), 32'd5);
        chk("drop5_sat", 32'(rr_drop), 32'd3);
        chk("drop_held", fx_instr, 32'hF800_0000);
        chk("drop_pend", 32'(fx_pend), 32'b00010);

        // reset in the middle of a handshake
        reset = 1'b1;
        cyc(1);
        chk("mid_valid", 32'(fx_valid), 32'd0);
        chk("mid_instr", fx_instr, 32'd0);
        chk("mid_pend", 32'(fx_pend), 32'd0);
        chk("mid_drop", 32'(fx_drop), 32'd0);
        reset = 1'b0;
        cyc(10);
        chk("no_reissue", 32'(fx_valid), 32'd0);

        // key held through reset gives exactly one event
        keys = 4'b0100;
        do_reset();
        grant_fx("held_key", 32'hF800_0002);
        cyc(10);
        chk("held_once", 32'(fx_valid), 32'd0);
        chk("held_pend", 32'(fx_pend), 32'd0);
        keys = '0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
